// File: rtl/cpu_pkg.sv
// Shared RV32I control types: ALU operation encoding, opcode constants and
// the multi-cycle controller state encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSlt = 3'd7
  } alu_op_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StWriteback = 3'd3,
    StHalt      = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of an RV32I R-type / I-type ALU instruction into ALU
// operation, immediate select and an illegal-encoding flag.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  output alu_op_t     alu_op_o,
  output logic        use_imm_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       f7_zero;
  logic       is_shift;
  alu_op_t    f3_op;

  assign opcode   = ir_i[6:0];
  assign funct3   = ir_i[14:12];
  assign funct7   = ir_i[31:25];
  assign f7_zero  = (funct7 == 7'b0000000);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    f3_op = AluAdd;
    unique case (funct3)
      3'b000:  f3_op = AluAdd;
      3'b001:  f3_op = AluSll;
      3'b010:  f3_op = AluSlt;
      3'b011:  f3_op = AluAdd;
      3'b100:  f3_op = AluXor;
      3'b101:  f3_op = AluSrl;
      3'b110:  f3_op = AluOr;
      3'b111:  f3_op = AluAnd;
      default: f3_op = AluAdd;
    endcase
  end

  always_comb begin
    alu_op_o  = AluAdd;
    use_imm_o = 1'b0;
    illegal_o = 1'b0;
    unique case (opcode)
      OP_R: begin
        // Only SUB may carry a non-zero funct7; SRA and the rest are rejected.
        illegal_o = (funct3 == 3'b011) ||
                    !(f7_zero || (funct3 == 3'b000 && funct7 == 7'b0100000));
        alu_op_o  = (funct3 == 3'b000 && funct7 == 7'b0100000) ? AluSub : f3_op;
      end
      OP_IMM: begin
        use_imm_o = 1'b1;
        illegal_o = (funct3 == 3'b011) || (is_shift && !f7_zero);
        alu_op_o  = f3_op;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch (ready handshake), decode, execute,
// writeback, with a sticky halt on illegal encodings or external request.
module rv32_multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [31:0] instruction,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        ir_write,
  output alu_op_t     alu_op,
  output logic        use_imm,
  output logic        reg_write,
  output logic        pc_write,
  output logic        halted,
  output logic        illegal_instr,
  output logic [31:0] retired_count
);

  ctrl_state_t state_q, state_d;
  logic [31:0] ir_q;
  alu_op_t     alu_op_q;
  logic        use_imm_q, reg_write_q, pc_write_q, halted_q, illegal_q;
  logic [31:0] retired_q;

  alu_op_t     dec_op;
  logic        dec_imm, dec_illegal;

  alu_decoder u_alu_decoder (
    .ir_i      (ir_q),
    .alu_op_o  (dec_op),
    .use_imm_o (dec_imm),
    .illegal_o (dec_illegal)
  );

  assign imem_req = (state_q == StFetch) && !reset;
  assign ir_write = imem_req && imem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:     if (imem_ready) state_d = StDecode;
      StDecode:    state_d = dec_illegal ? StHalt : StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = halt_req ? StHalt : StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      ir_q        <= '0;
      alu_op_q    <= AluAdd;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      if (ir_write) ir_q <= instruction;
      if (state_q == StDecode && !dec_illegal) begin
        alu_op_q  <= dec_op;
        use_imm_q <= dec_imm;
      end
      if (state_q == StDecode && dec_illegal) illegal_q <= 1'b1;
      // Writeback strobes and the retire count are registered on entry to
      // WRITEBACK so they are visible for exactly that cycle.
      if (state_q == StExecute) begin
        reg_write_q <= (ir_q[11:7] != 5'd0);
        pc_write_q  <= 1'b1;
        retired_q   <= retired_q + 32'd1;
      end
      if (state_d == StHalt) halted_q <= 1'b1;
    end
  end

  assign alu_op        = alu_op_q;
  assign use_imm       = use_imm_q;
  assign reg_write     = reg_write_q;
  assign pc_write      = pc_write_q;
  assign halted        = halted_q;
  assign illegal_instr = illegal_q;
  assign retired_count = retired_q;

endmodule
